// File: rtl/binary_mac_sequencer_if.sv
// Operand stream, dot-product unit link and result channel of the MAC sequencer.
// slave = sequencer side, master = streamer/consumer/dot-product unit side.
interface binary_mac_sequencer_if #(
  parameter int SIZE    = 2,
  parameter int SETS    = 2,
  parameter int MAX_LEN = 8
);
  localparam int DP_W  = (SIZE << 1) + SETS;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int ACC_W = DP_W + $clog2(MAX_LEN);
  localparam int VEC_W = SETS * SIZE;

  logic             start;
  logic [LEN_W-1:0] len;
  logic             in_valid;
  logic             in_ready;
  logic [VEC_W-1:0] in_a;
  logic [VEC_W-1:0] in_b;
  logic             dp_valid;
  logic [VEC_W-1:0] dp_a;
  logic [VEC_W-1:0] dp_b;
  logic [DP_W-1:0]  dp_sum;
  logic             res_valid;
  logic             res_ready;
  logic [ACC_W-1:0] res_data;
  logic             busy;

  modport slave (
    input  start, len, in_valid, in_a, in_b, dp_sum, res_ready,
    output in_ready, dp_valid, dp_a, dp_b, res_valid, res_data, busy
  );

  modport master (
    output start, len, in_valid, in_a, in_b, dp_sum, res_ready,
    input  in_ready, dp_valid, dp_a, dp_b, res_valid, res_data, busy
  );
endinterface

// File: rtl/binary_mac_sequencer.sv
// Feeds operand beats through registered dp_* ports to an external dot-product unit and
// accumulates its per-beat sum over a run of up to MAX_LEN beats.
module binary_mac_sequencer #(
  parameter int SIZE    = 2,
  parameter int SETS    = 2,
  parameter int MAX_LEN = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  binary_mac_sequencer_if.slave bus
);
  localparam int DP_W  = (SIZE << 1) + SETS;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int ACC_W = DP_W + $clog2(MAX_LEN);
  localparam int VEC_W = SETS * SIZE;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, DONE} state_t;

  state_t           state_q;
  logic [LEN_W-1:0] eff_len_q, issued_q, added_q;
  logic [ACC_W-1:0] acc_q, res_data_q;
  logic [VEC_W-1:0] dp_a_q, dp_b_q;
  logic             dp_valid_q, in_ready_q, res_valid_q, busy_q;

  logic [LEN_W-1:0] len_sat, issued_d, added_d;
  logic [ACC_W-1:0] acc_d;
  logic             hs, add_en;

  assign len_sat  = (bus.len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.len;
  // in_ready is a register, so the handshake never loops back through in_valid
  assign hs       = bus.in_valid & in_ready_q;
  assign issued_d = issued_q + 1'b1;
  assign added_d  = added_q + 1'b1;
  assign acc_d    = acc_q + ACC_W'(bus.dp_sum);
  assign add_en   = dp_valid_q && (added_q < eff_len_q);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      eff_len_q   <= '0;
      issued_q    <= '0;
      added_q     <= '0;
      acc_q       <= '0;
      res_data_q  <= '0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
      dp_valid_q  <= 1'b0;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.start) begin
          eff_len_q <= len_sat;
          acc_q     <= '0;
          issued_q  <= '0;
          added_q   <= '0;
          busy_q    <= 1'b1;
          if (len_sat == '0) begin
            res_data_q  <= '0;
            res_valid_q <= 1'b1;
            state_q     <= DONE;
          end else begin
            in_ready_q <= 1'b1;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (add_en) begin
            acc_q   <= acc_d;
            added_q <= added_d;
          end
          if (hs) begin
            dp_a_q     <= bus.in_a;
            dp_b_q     <= bus.in_b;
            dp_valid_q <= 1'b1;
            issued_q   <= issued_d;
            if (issued_d == eff_len_q) begin
              in_ready_q <= 1'b0;
              state_q    <= DRAIN;
            end
          end else begin
            dp_valid_q <= 1'b0;
          end
        end
        DRAIN: begin
          // last beat's sum is folded straight into the presented result
          dp_valid_q  <= 1'b0;
          res_valid_q <= 1'b1;
          state_q     <= DONE;
          if (add_en) begin
            acc_q      <= acc_d;
            added_q    <= added_d;
            res_data_q <= acc_d;
          end else begin
            res_data_q <= acc_q;
          end
        end
        DONE: if (bus.res_ready) begin
          res_valid_q <= 1'b0;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.dp_valid  = dp_valid_q;
  assign bus.dp_a      = dp_a_q;
  assign bus.dp_b      = dp_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_binary_mac_sequencer.sv
// Table-driven runs plus hand sequences for backpressure and mid-run reset; results are
// checked against a queue of expected values pushed at start time.
module tb_binary_mac_sequencer;
  localparam int SIZE    = 2;
  localparam int SETS    = 2;
  localparam int MAX_LEN = 8;
  localparam int DP_W    = (SIZE << 1) + SETS;
  localparam int LEN_W   = $clog2(MAX_LEN + 1);
  localparam int VEC_W   = SETS * SIZE;

  typedef struct {
    int                             len;
    logic [MAX_LEN-1:0][VEC_W-1:0] a;
    logic [MAX_LEN-1:0][VEC_W-1:0] b;
    int                             exp_res;
    int                             exp_beats;
  } vec_t;

  logic clk, rst_n;
  int   checks = 0, passed = 0;
  logic [31:0] sb[$];
  vec_t vecs[5];

  binary_mac_sequencer_if #(.SIZE(SIZE), .SETS(SETS), .MAX_LEN(MAX_LEN)) bus();

  binary_mac_sequencer #(.SIZE(SIZE), .SETS(SETS), .MAX_LEN(MAX_LEN)) dut (
    .clock  (clk),
    .reset_n(rst_n),
    .bus    (bus.slave)
  );

  // behavioural stand-in for the combinational dot-product unit
  always_comb begin
    logic [DP_W-1:0] s;
    s = '0;
    for (int i = 0; i < SETS; i++)
      s = s + DP_W'(bus.dp_a[i*SIZE +: SIZE]) * DP_W'(bus.dp_b[i*SIZE +: SIZE]);
    bus.dp_sum = s;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) $display("FAIL %s: got %0d, required %0d", name, act, exp);
    else passed++;
  endtask

  function automatic int sw_dot(input vec_t v);
    int n, s;
    n = (v.len > MAX_LEN) ? MAX_LEN : v.len;
    s = 0;
    for (int k = 0; k < n; k++)
      for (int i = 0; i < SETS; i++)
        s += int'(v.a[k][i*SIZE +: SIZE]) * int'(v.b[k][i*SIZE +: SIZE]);
    return s;
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({bus.in_ready, bus.dp_valid, bus.dp_a, bus.dp_b,
                bus.res_valid, bus.res_data, bus.busy});
  endfunction

  // Called at a negedge; start is driven in that very cycle so back-to-back runs are exercised.
  task automatic run_vec(input vec_t v, input bit bubbles, input int hold, input bit poke_start);
    int acc_n, cyc, last_hs;
    bit seen;
    logic [31:0] held, exp;
    acc_n = 0; cyc = 0; last_hs = -1; seen = 1'b0;
    bus.start = 1'b1;
    bus.len   = LEN_W'(v.len);
    sb.push_back(v.exp_res);
    @(negedge clk);
    bus.start = 1'b0;
    bus.len   = '0;
    chk("busy_in_run", bus.busy, 1);
    while (!seen && cyc < 200) begin
      if (bus.res_valid) seen = 1'b1;
      else begin
        bus.in_valid = bubbles ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.in_a = (acc_n < MAX_LEN) ? v.a[acc_n] : '0;
        bus.in_b = (acc_n < MAX_LEN) ? v.b[acc_n] : '0;
        if (bus.in_valid && bus.in_ready) begin
          acc_n++;
          last_hs = cyc;
        end
        @(negedge clk);
        cyc++;
      end
    end
    bus.in_valid = 1'b0;
    chk("res_valid_timeout", 32'(seen), 1);
    if (!seen) begin
      void'(sb.pop_front());
      return;
    end
    chk("beats_accepted", acc_n, v.exp_beats);
    if (v.exp_beats == 0) chk("len0_latency", cyc, 0);
    else chk("res_latency", cyc - last_hs, 2);
    held = 32'(bus.res_data);
    for (int h = 0; h < hold; h++) begin
      bus.start = poke_start;
      bus.res_ready = 1'b0;
      @(negedge clk);
      chk("hold_valid", bus.res_valid, 1);
      chk("hold_data", 32'(bus.res_data), held);
    end
    bus.start = poke_start;
    bus.res_ready = 1'b1;
    exp = sb.pop_front();
    chk("res_valid", bus.res_valid, 1);
    chk("res_data", 32'(bus.res_data), exp);
    @(negedge clk);
    bus.res_ready = 1'b0;
    bus.start = 1'b0;
    chk("post_res_valid", bus.res_valid, 0);
    chk("post_busy", bus.busy, 0);
  endtask

  initial begin
    vec_t rv;
    int n, c;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.in_valid = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.res_ready = 1'b0;

    for (int i = 0; i < 5; i++) begin
      vecs[i].a = '0; vecs[i].b = '0;
    end
    // {p1,p0} packing: 4'b1011 = {2,3}
    vecs[0].len = 3;  vecs[0].exp_res = 22;  vecs[0].exp_beats = 3;
    vecs[0].a[0] = 4'b1011; vecs[0].b[0] = 4'b0111;
    vecs[0].a[1] = 4'b1101; vecs[0].b[1] = 4'b1110;
    vecs[0].a[2] = 4'b0000; vecs[0].b[2] = 4'b1111;
    vecs[1].len = 8;  vecs[1].exp_res = 144; vecs[1].exp_beats = 8;
    vecs[2].len = 0;  vecs[2].exp_res = 0;   vecs[2].exp_beats = 0;
    vecs[3].len = 12; vecs[3].exp_res = 32;  vecs[3].exp_beats = 8;
    vecs[4].len = 1;  vecs[4].exp_res = 2;   vecs[4].exp_beats = 1;
    vecs[4].a[0] = 4'b0101; vecs[4].b[0] = 4'b0101;
    for (int k = 0; k < MAX_LEN; k++) begin
      vecs[1].a[k] = 4'hF;    vecs[1].b[k] = 4'hF;
      vecs[2].a[k] = 4'hF;    vecs[2].b[k] = 4'hF;
      vecs[3].a[k] = 4'b1010; vecs[3].b[k] = 4'b0101;
    end

    @(negedge clk); @(negedge clk);
    chk("reset_outputs", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("busy_after_reset", bus.busy, 0);

    for (int i = 0; i < 4; i++) run_vec(vecs[i], 1'b0, 1, 1'b0);

    // random operands, in_valid bubbles, long result backpressure, start poked during DONE
    rv.len = 5; rv.a = '0; rv.b = '0;
    for (int k = 0; k < 5; k++) begin
      rv.a[k] = VEC_W'($urandom);
      rv.b[k] = VEC_W'($urandom);
    end
    rv.exp_res = sw_dot(rv); rv.exp_beats = 5;
    run_vec(rv, 1'b1, 5, 1'b1);
    rv.len = 7;
    for (int k = 0; k < 7; k++) begin
      rv.a[k] = VEC_W'($urandom);
      rv.b[k] = VEC_W'($urandom);
    end
    rv.exp_res = sw_dot(rv); rv.exp_beats = 7;
    run_vec(rv, 1'b1, 2, 1'b0);

    // reset after 2 of 4 beats, then a fresh len=1 run must not see stale accumulation
    bus.start = 1'b1; bus.len = 4'd4;
    @(negedge clk);
    bus.start = 1'b0; bus.len = '0;
    bus.in_valid = 1'b1; bus.in_a = 4'hF; bus.in_b = 4'hF;
    n = 0; c = 0;
    while (n < 2 && c < 20) begin
      if (bus.in_ready) n++;
      @(negedge clk);
      c++;
    end
    bus.in_valid = 1'b0;
    chk("midrun_beats", n, 2);
    rst_n = 1'b0;
    #1;
    chk("midrun_reset_outputs", all_outs(), 0);
    @(negedge clk);
    chk("midrun_reset_hold", all_outs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrun_busy_after", bus.busy, 0);
    run_vec(vecs[4], 1'b0, 0, 1'b0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
